flash_arbiter: RTL

FLASH_ARBITER -- requirements
Module: flash_arbiter

---
 rtl/flash_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/flash_arbiter.sv
`default_nettype none
// flash_arbiter -- two-port round-robin arbiter that sequences NOR-flash reads
// and byte programs on one shared flash bus. Rev 1.0
module flash_arbiter #(
  parameter int READ_WAIT   = 6,
  parameter int WE_PULSE    = 4,
  parameter int STS_TIMEOUT = 50000
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       NF_CE,
  output logic       NF_OE,
  output logic       NF_WE,
  output logic [7:0] NF_A,
  output logic [7:0] NF_DO,
  output logic       NF_DOE,
  input  logic [7:0] NF_DI,
  input  logic       NF_STS
);

  localparam logic [15:0] RD_LAST    = 16'((READ_WAIT < 1 ? 1 : READ_WAIT) - 1);
  localparam logic [15:0] WE_LAST    = 16'((WE_PULSE < 1 ? 1 : WE_PULSE) - 1);
  localparam logic [15:0] GAP_LAST   = 16'd1;
  localparam logic [15:0] STS_IGNORE = 16'd2;
  localparam logic [15:0] STS_LAST   = 16'(STS_TIMEOUT + 1);
  localparam logic [7:0]  PROG_CMD   = 8'h40;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACTIVE = 3'd1,
    WR_CMD    = 3'd2,
    WR_GAP    = 3'd3,
    WR_DATA   = 3'd4,
    WR_STS    = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic        gnt, gnt_nx;
  logic        last, last_nx;
  logic        op_we, op_we_nx;
  logic [7:0]  op_addr, op_addr_nx;
  logic [7:0]  op_wdata, op_wdata_nx;
  logic [7:0]  rdata_nx;
  logic        err_nx;
  logic        pick;

  logic        ce_nx, oe_nx, wen_nx, doe_nx;
  logic        done0_nx, done1_nx, busy_nx;
  logic [7:0]  a_nx, do_nx;

  // On a tie the port that was not served last wins; otherwise the sole requester.
  assign pick = (req0 && req1) ? ~last : req1;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + 16'd1;
    gnt_nx      = gnt;
    last_nx     = last;
    op_we_nx    = op_we;
    op_addr_nx  = op_addr;
    op_wdata_nx = op_wdata;
    rdata_nx    = rdata;
    err_nx      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (req0 || req1) begin
          gnt_nx      = pick;
          op_we_nx    = pick ? we1 : we0;
          op_addr_nx  = pick ? addr1 : addr0;
          op_wdata_nx = pick ? wdata1 : wdata0;
          state_nx    = (pick ? we1 : we0) ? WR_CMD : RD_ACTIVE;
        end
      end
      RD_ACTIVE: begin
        if (cnt == RD_LAST) begin
          rdata_nx = NF_DI;
          cnt_nx   = '0;
          state_nx = DONE;
        end
      end
      WR_CMD: begin
        if (cnt == WE_LAST) begin
          cnt_nx   = '0;
          state_nx = WR_GAP;
        end
      end
      WR_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          state_nx = WR_DATA;
        end
      end
      WR_DATA: begin
        if (cnt == WE_LAST) begin
          cnt_nx   = '0;
          state_nx = WR_STS;
        end
      end
      WR_STS: begin
        // Status is unreliable right after the data strobe, so the first cycles are skipped.
        if (cnt >= STS_IGNORE && NF_STS) begin
          cnt_nx   = '0;
          state_nx = DONE;
        end else if (cnt == STS_LAST) begin
          cnt_nx   = '0;
          err_nx   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        cnt_nx   = '0;
        last_nx  = gnt;
        state_nx = IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // Bus outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    ce_nx    = 1'b1;
    oe_nx    = 1'b1;
    wen_nx   = 1'b1;
    doe_nx   = 1'b0;
    a_nx     = NF_A;
    do_nx    = NF_DO;
    busy_nx  = (state_nx != IDLE);
    done0_nx = (state_nx == DONE) && !gnt_nx;
    done1_nx = (state_nx == DONE) && gnt_nx;
    if (state_nx != IDLE && state_nx != DONE) begin
      a_nx = op_addr_nx;
    end
    case (state_nx)
      RD_ACTIVE: begin
        ce_nx = 1'b0;
        oe_nx = 1'b0;
      end
      WR_CMD: begin
        ce_nx  = 1'b0;
        wen_nx = 1'b0;
        doe_nx = 1'b1;
        do_nx  = PROG_CMD;
      end
      WR_GAP: begin
        doe_nx = 1'b1;
        do_nx  = op_wdata_nx;
      end
      WR_DATA: begin
        ce_nx  = 1'b0;
        wen_nx = 1'b0;
        doe_nx = 1'b1;
        do_nx  = op_wdata_nx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt      <= 1'b0;
      last     <= 1'b1;
      op_we    <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
      NF_CE    <= 1'b1;
      NF_OE    <= 1'b1;
      NF_WE    <= 1'b1;
      NF_DOE   <= 1'b0;
      NF_A     <= '0;
      NF_DO    <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      gnt      <= gnt_nx;
      last     <= last_nx;
      op_we    <= op_we_nx;
      op_addr  <= op_addr_nx;
      op_wdata <= op_wdata_nx;
      rdata    <= rdata_nx;
      err      <= err_nx;
      done0    <= done0_nx;
      done1    <= done1_nx;
      busy     <= busy_nx;
      NF_CE    <= ce_nx;
      NF_OE    <= oe_nx;
      NF_WE    <= wen_nx;
      NF_DOE   <= doe_nx;
      NF_A     <= a_nx;
      NF_DO    <= do_nx;
    end
  end

endmodule
`default_nettype wire
